// File: rtl/sw_bcd_chain_if.sv
// sw_bcd_chain_if: control inputs and BCD outputs of one stopwatch counter stage
interface sw_bcd_chain_if #(parameter int DIGITS = 2);
    logic                  tick;
    logic                  run;
    logic                  up;
    logic                  clear;
    logic                  lap;
    logic [4*DIGITS-1:0]   count;
    logic [4*DIGITS-1:0]   display;
    logic                  frozen;
    logic                  carry;
    logic                  zero;
    modport master (output tick, run, up, clear, lap, input count, display, frozen, carry, zero);
    modport slave (input tick, run, up, clear, lap, output count, display, frozen, carry, zero);
endinterface

// File: rtl/sw_bcd_chain.sv
// sw_bcd_chain: parametrised up/down BCD cascade counter with lap-freeze display
module sw_bcd_chain #(
    parameter int DIGITS  = 2,
    parameter int TOP_MOD = 10
) (
    input logic clk,
    input logic reset,
    sw_bcd_chain_if.slave bus
);
    localparam int W = 4 * DIGITS;
    logic [W-1:0]    count, lap_reg, nxt;
    logic            frozen, carry, zero, step;
    logic [DIGITS:0] en;
    assign step = bus.tick & bus.run & ~bus.clear;
    assign en[0] = 1'b1;
    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_dig
            localparam logic [3:0] MX = (i == DIGITS - 1) ? 4'(TOP_MOD - 1) : 4'd9;
            logic [3:0] d;
            assign d = count[4*i +: 4];
            assign en[i+1] = en[i] & (bus.up ? d == MX : d == 4'd0);
            assign nxt[4*i +: 4] = !en[i] ? d :
                                   bus.up ? (d == MX ? 4'd0 : d + 4'd1) :
                                            (d == 4'd0 ? MX : d - 4'd1);
        end
    endgenerate
    // counter, flags and lap register; clear overrides step and lap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            lap_reg <= '0;
            frozen  <= 1'b0;
            carry   <= 1'b0;
            zero    <= 1'b1;
        end else if (bus.clear) begin
            count  <= '0;
            carry  <= 1'b0;
            frozen <= 1'b0;
            zero   <= 1'b1;
        end else begin
            if (step) count <= nxt;
            carry <= step & en[DIGITS];
            zero  <= (step ? nxt : count) == '0;
            if (bus.lap) begin
                if (!frozen) lap_reg <= count;
                frozen <= ~frozen;
            end
        end
    end
    assign bus.count   = count;
    assign bus.display = frozen ? lap_reg : count;
    assign bus.frozen  = frozen;
    assign bus.carry   = carry;
    assign bus.zero    = zero;
endmodule

// File: tb/tb_sw_bcd_chain.sv
// tb_sw_bcd_chain: directed and random checks of two counter configurations against an integer model
module tb_sw_bcd_chain;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    int mn[2], mlap[2];
    bit mfr[2], mcar[2], mzero[2];
    sw_bcd_chain_if #(.DIGITS(2)) ia ();
    sw_bcd_chain_if #(.DIGITS(4)) ib ();
    sw_bcd_chain #(.DIGITS(2), .TOP_MOD(6))  dut_a (.clk(clk), .reset(rst_n), .bus(ia));
    sw_bcd_chain #(.DIGITS(4), .TOP_MOD(10)) dut_b (.clk(clk), .reset(rst_n), .bus(ib));
    always #5 clk = ~clk;

    function automatic int total(int k);
        return k == 0 ? 60 : 10000;
    endfunction

    function automatic logic [31:0] bcd(int v);
        logic [31:0] r = '0;
        for (int j = 0; j < 8; j++) begin
            r[4*j +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mn[k] = 0; mlap[k] = 0; mfr[k] = 0; mcar[k] = 0; mzero[k] = 1;
        end
    endtask

    task automatic model_step(bit t, bit r, bit u, bit c, bit l);
        for (int k = 0; k < 2; k++) begin
            int old = mn[k];
            if (c) begin
                mn[k] = 0; mcar[k] = 0; mfr[k] = 0;
            end else begin
                mcar[k] = 0;
                if (t && r) begin
                    mcar[k] = u ? (old == total(k) - 1) : (old == 0);
                    mn[k] = u ? (old + 1) % total(k) : (old + total(k) - 1) % total(k);
                end
                if (l) begin
                    if (!mfr[k]) mlap[k] = old;
                    mfr[k] = !mfr[k];
                end
            end
            mzero[k] = mn[k] == 0;
        end
    endtask

    task automatic chk_all();
        chk("a_count",   32'(ia.count),   bcd(mn[0]));
        chk("a_display", 32'(ia.display), bcd(mfr[0] ? mlap[0] : mn[0]));
        chk("a_frozen",  32'(ia.frozen),  32'(mfr[0]));
        chk("a_carry",   32'(ia.carry),   32'(mcar[0]));
        chk("a_zero",    32'(ia.zero),    32'(mzero[0]));
        chk("b_count",   32'(ib.count),   bcd(mn[1]));
        chk("b_display", 32'(ib.display), bcd(mfr[1] ? mlap[1] : mn[1]));
        chk("b_frozen",  32'(ib.frozen),  32'(mfr[1]));
        chk("b_carry",   32'(ib.carry),   32'(mcar[1]));
        chk("b_zero",    32'(ib.zero),    32'(mzero[1]));
    endtask

    task automatic cyc(bit t, bit r, bit u, bit c, bit l);
        ia.tick = t; ia.run = r; ia.up = u; ia.clear = c; ia.lap = l;
        ib.tick = t; ib.run = r; ib.up = u; ib.clear = c; ib.lap = l;
        model_step(t, r, u, c, l);
        @(posedge clk);
        #1;
        chk_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all();
        rst_n = 1'b1;
    endtask

    initial begin
        ia.tick = 0; ia.run = 0; ia.up = 0; ia.clear = 0; ia.lap = 0;
        ib.tick = 0; ib.run = 0; ib.up = 0; ib.clear = 0; ib.lap = 0;
        do_reset();
        chk("rst_zero", 32'(ia.zero), 32'd1);
        chk("rst_display", 32'(ia.display), 32'h0);
        // up count and wrap through 00..59
        repeat (59) cyc(1, 1, 1, 0, 0);
        chk("up_59", 32'(ia.count), 32'h59);
        cyc(1, 1, 1, 0, 0);
        chk("wrap_count", 32'(ia.count), 32'h00);
        chk("wrap_carry", 32'(ia.carry), 32'd1);
        chk("wrap_zero", 32'(ia.zero), 32'd1);
        cyc(0, 1, 1, 0, 0);
        chk("carry_one_cycle", 32'(ia.carry), 32'd0);
        // down count and borrow
        cyc(1, 1, 0, 0, 0);
        chk("borrow_count", 32'(ia.count), 32'h59);
        chk("borrow_carry", 32'(ia.carry), 32'd1);
        cyc(1, 1, 0, 0, 0);
        chk("down_58", 32'(ia.count), 32'h58);
        chk("down_carry0", 32'(ia.carry), 32'd0);
        // hold, then sparse ticks
        repeat (5) cyc(1, 0, 1, 0, 0);
        chk("hold", 32'(ia.count), 32'h58);
        repeat (3) begin
            cyc(1, 1, 1, 0, 0);
            cyc(0, 1, 1, 0, 0);
            cyc(0, 1, 1, 0, 0);
        end
        chk("sparse", 32'(ia.count), 32'h01);
        // lap freeze
        repeat (22) cyc(1, 1, 1, 0, 0);
        chk("pre_lap", 32'(ia.count), 32'h23);
        cyc(1, 1, 1, 0, 1);
        chk("lap_display", 32'(ia.display), 32'h23);
        chk("lap_count", 32'(ia.count), 32'h24);
        chk("lap_frozen", 32'(ia.frozen), 32'd1);
        repeat (10) cyc(1, 1, 1, 0, 0);
        chk("frozen_display", 32'(ia.display), 32'h23);
        cyc(0, 1, 1, 0, 1);
        chk("unlap_display", 32'(ia.display), 32'h34);
        chk("unlap_frozen", 32'(ia.frozen), 32'd0);
        // clear precedence over tick and lap
        repeat (25) cyc(1, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 1);
        chk("pre_clear", 32'(ia.count), 32'h59);
        cyc(1, 1, 1, 1, 1);
        chk("clr_count", 32'(ia.count), 32'h00);
        chk("clr_carry", 32'(ia.carry), 32'd0);
        chk("clr_frozen", 32'(ia.frozen), 32'd0);
        chk("clr_zero", 32'(ia.zero), 32'd1);
        // four-digit wrap
        do_reset();
        repeat (9999) cyc(1, 1, 1, 0, 0);
        chk("b_9999", 32'(ib.count), 32'h9999);
        cyc(1, 1, 1, 0, 0);
        chk("b_wrap", 32'(ib.count), 32'h0000);
        chk("b_wrap_carry", 32'(ib.carry), 32'd1);
        cyc(0, 1, 1, 0, 0);
        chk("b_carry_drop", 32'(ib.carry), 32'd0);
        // random stimulus
        for (int n = 0; n < 2000; n++)
            cyc(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
        // asynchronous reset between edges
        repeat (7) cyc(1, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_all();
        chk("async_b_count", 32'(ib.count), 32'h0);
        #2;
        rst_n = 1'b1;
        cyc(1, 1, 1, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sw_bcd_chain.md
# sw_bcd_chain

Parametrised multi-digit BCD cascade counter for the stopwatch datapath. It generalises the fixed two-digit centisecond stage: configurable digit count and top-digit modulus, up/down counting, run/hold, synchronous clear and a lap-freeze display register. It is clocked by the system clock and advanced by a one-cycle `tick` enable. Instances chain via `carry` into the next stage's `tick`.

## Interface
- `DIGITS`, 2: number of BCD digits; legal 1..8.
- `TOP_MOD`, 10: modulus of the most significant digit; legal 2..10 (6 gives 00..59 for seconds/minutes).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `tick`  in  1  count enable, nominally a one-cycle pulse from the previous stage.
- `run`  in  1  level; 1 = count on `tick`, 0 = hold.
- `up`  in  1  direction; 1 = increment, 0 = decrement.
- `clear`  in  1  synchronous clear to zero.
- `lap`  in  1  pulse; toggles the lap freeze.
- `count`  out  4*DIGITS  live BCD value; digit 0 is `count[3:0]` (least significant).
- `display`  out  4*DIGITS  `lap_reg` when `frozen`=1, otherwise `count`; combinational mux.
- `frozen`  out  1  lap freeze active.
- `carry`  out  1  registered one-cycle wrap pulse.
- `zero`  out  1  registered; 1 when `count` is all zeros.

## Operation
- Step condition: `tick & run & ~clear`.
- Digits 0..DIGITS-2 use modulus 10; digit DIGITS-1 uses `TOP_MOD`.
- Up: digit i increments when all lower digits are at their maximum, and wraps max→0. Digit 0 increments on every step.
- Down: digit i decrements when all lower digits are 0, and wraps 0→max. Digit 0 decrements on every step.
- `carry` is 1 for exactly the cycle following a step that wrapped the whole chain, otherwise 0:
  - up: all digits at max → all 0;
  - down: all 0 → all at max.
- `up` is sampled per step; changing it between ticks is legal.
- Lap: `lap`=1 with `frozen`=0 → `lap_reg` ← `count` as it was before this edge's step, and `frozen` ← 1. `lap`=1 with `frozen`=1 → `frozen` ← 0; `lap_reg` is left unchanged.
- `clear`=1 → `count` ← 0, `carry` ← 0, `frozen` ← 0, `zero` ← 1. `tick` and `lap` in the same cycle are ignored; `lap_reg` is left unchanged.
- Priority: reset > clear > (step, lap). Step and lap are independent when they coincide.
- Non-BCD digit values are unreachable; no recovery logic is required.

## Timing
- Reset (asynchronous assertion, synchronous effect on release): `count`=0, `lap_reg`=0, `frozen`=0, `carry`=0, `zero`=1. `display` therefore reads 0.
- Latency: one clock from a `tick` edge to the updated `count`, `zero` and `carry`.
- `carry` is registered, so a cascade adds one cycle per stage. Downstream stages see their `tick` one clock after the upstream wrap edge.
- `display` follows `frozen`/`count` combinationally within the same cycle.
- `tick` held high for N cycles with `run`=1 gives N steps. No edge detection is performed.
- `reset` asserted mid-count clears all registers immediately, without waiting for a clock edge.

## Test plan
Unless noted, `DIGITS`=2, `TOP_MOD`=6.
- Up count and wrap: reset, `run`=1, `up`=1, 60 single-cycle ticks → `count` walks 0x00..0x59; the 60th tick gives `count`=0x00 with `carry`=1 for one cycle only, and `zero`=1.
- Down count and borrow: from 0x00 with `up`=0, one tick → `count`=0x59, `carry`=1. A further tick → 0x58, `carry`=0.
- Hold: `run`=0 with 5 ticks → `count` unchanged. Then `run`=1 with ticks on every 3rd cycle → one step per tick.
- Lap: with `count`=0x23, assert `lap` and `tick` in the same cycle → `display`=0x23, `count`=0x24, `frozen`=1. After 10 more ticks, `display` is still 0x23. A second `lap` → `display`=`count`=0x34.
- Clear precedence: `count`=0x59 with `frozen`=1; `clear`, `tick` and `lap` together → `count`=0x00, `carry`=0, `frozen`=0.
- Width and asynchronous reset: `DIGITS`=4, `TOP_MOD`=10, preload to 9999 by ticking → next tick gives 0000 with `carry` pulse. Dropping `reset` between clock edges zeroes all outputs before the next clock edge.
